// File: rtl/lspc_timing_pkg.sv
// ---------------------------------------------------------------------------
// lspc_timing_pkg
// Shared constants and helpers for the LSPC raster timing generator.
//   - Vertical raster landmarks (first line per mode, last line, blanking
//     window, vertical sync length).
//   - vmode_e : video standard selector (NTSC / PAL).
//   - v_first_of() : first raster line for a given standard.
// ---------------------------------------------------------------------------
package lspc_timing_pkg;

    localparam logic [8:0] V_FIRST_NTSC = 9'h0F8;
    localparam logic [8:0] V_FIRST_PAL  = 9'h0C8;
    localparam logic [8:0] V_LAST       = 9'h1FF;
    localparam logic [8:0] VBL_START    = 9'h1F0;
    localparam logic [8:0] VBL_END      = 9'h110;
    localparam logic [8:0] VSYNC_LEN    = 9'd8;

    typedef enum logic {
        VMODE_NTSC = 1'b0,
        VMODE_PAL  = 1'b1
    } vmode_e;

    function automatic logic [8:0] v_first_of(input vmode_e mode);
        return (mode == VMODE_PAL) ? V_FIRST_PAL : V_FIRST_NTSC;
    endfunction

endpackage

// File: rtl/lspc_wrap_cnt.sv
// ---------------------------------------------------------------------------
// lspc_wrap_cnt
// 9-bit counter with enable, wrap detection and reload value. Used for both
// the horizontal pixel counter and the vertical raster counter.
//   CLK      in   system clock
//   nRESETP  in   asynchronous active-low reset (counter -> RST_VAL)
//   en       in   advance the counter this cycle
//   last     in   final count; the counter reloads after it
//   load     in   value taken when wrapping
//   cnt      out  current (registered) count
//   cnt_nxt  out  value cnt will hold after this clock edge
//   wrap     out  en is set and cnt == last (reload happens this edge)
// ---------------------------------------------------------------------------
module lspc_wrap_cnt #(
    parameter logic [8:0] RST_VAL = 9'd0
) (
    input  logic       CLK,
    input  logic       nRESETP,
    input  logic       en,
    input  logic [8:0] last,
    input  logic [8:0] load,
    output logic [8:0] cnt,
    output logic [8:0] cnt_nxt,
    output logic       wrap
);

    assign wrap = en && (cnt == last);

    // The next value is exported so downstream decoders can register their
    // outputs on the same edge the counter moves.
    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = wrap ? load : cnt + 9'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            cnt <= RST_VAL;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/lspc_video_timing.sv
// ---------------------------------------------------------------------------
// lspc_video_timing
// Raster timing generator driven by the 6 MHz pixel enable. Keeps the
// horizontal and vertical counters and produces registered sync, blanking
// and event strobes.
//
// Optional feature: define LSPC_SNAP_EN to build the V_CNT snapshot register
// (SNAP_V). Without it SNAP_V is constant 0 and SNAP_REQ has no effect.
//
// Ports:
//   CLK           in   system clock
//   nRESETP       in   asynchronous active-low reset
//   LSPC_EN_6M_P  in   pixel enable, one CLK wide
//   VMODE         in   0 = NTSC (264 lines), 1 = PAL (312 lines)
//   SNAP_REQ      in   counter snapshot request
//   H_CNT         out  pixel counter 0..H_TOTAL-1
//   V_CNT         out  raster counter V_FIRST..0x1FF
//   nHSYNC        out  horizontal sync, active low
//   nVSYNC        out  vertical sync, active low
//   CHBL          out  horizontal blank
//   nBNKB         out  vertical blank, active low
//   LINE_START    out  one-CLK pulse after H_CNT wraps to 0
//   FRAME_START   out  one-CLK pulse after V_CNT reloads
//   VBL_IRQ       out  one-CLK pulse on reaching V_CNT=0x1F0, H_CNT=0
//   SNAP_V        out  latched V_CNT
// ---------------------------------------------------------------------------
module lspc_video_timing
    import lspc_timing_pkg::*;
#(
    parameter int H_TOTAL   = 384,
    parameter int HSYNC_LEN = 28,
    parameter int HBL_START = 376,
    parameter int HBL_END   = 56
) (
    input  logic       CLK,
    input  logic       nRESETP,
    input  logic       LSPC_EN_6M_P,
    input  logic       VMODE,
    input  logic       SNAP_REQ,
    output logic [8:0] H_CNT,
    output logic [8:0] V_CNT,
    output logic       nHSYNC,
    output logic       nVSYNC,
    output logic       CHBL,
    output logic       nBNKB,
    output logic       LINE_START,
    output logic       FRAME_START,
    output logic       VBL_IRQ,
    output logic [8:0] SNAP_V
);

    localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
    localparam logic [8:0] HSYNC_END  = 9'(HSYNC_LEN);
    localparam logic [8:0] HBL_END_C  = 9'(HBL_END);
    localparam logic [8:0] HBL_STRT_C = 9'(HBL_START);

    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       v_en;
    logic [8:0] v_load;
    logic [8:0] vs_first;
    vmode_e     mode_q;
    vmode_e     mode_nxt;
    vmode_e     vmode_in;

    assign vmode_in = vmode_e'(VMODE);

    // The raster counter only moves on the pixel enable that ends a line.
    assign v_en = LSPC_EN_6M_P & h_wrap;

    // VMODE is looked at only at the frame reload: the new frame starts on
    // the requested standard's first line and that standard stays active
    // until the next reload.
    assign v_load   = v_first_of(vmode_in);
    assign mode_nxt = v_wrap ? vmode_in : mode_q;
    assign vs_first = v_first_of(mode_nxt);

    lspc_wrap_cnt #(
        .RST_VAL (9'd0)
    ) u_h_cnt (
        .CLK     (CLK),
        .nRESETP (nRESETP),
        .en      (LSPC_EN_6M_P),
        .last    (H_LAST),
        .load    (9'd0),
        .cnt     (H_CNT),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap)
    );

    lspc_wrap_cnt #(
        .RST_VAL (V_FIRST_NTSC)
    ) u_v_cnt (
        .CLK     (CLK),
        .nRESETP (nRESETP),
        .en      (v_en),
        .last    (V_LAST),
        .load    (v_load),
        .cnt     (V_CNT),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap)
    );

    // Decoders work on the counters' next values so every level and pulse
    // changes on the same edge as the counters. With no enable the next
    // values equal the current ones, so levels hold and pulses drop.
    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            mode_q      <= VMODE_NTSC;
            nHSYNC      <= 1'b0;
            nVSYNC      <= 1'b0;
            CHBL        <= 1'b1;
            nBNKB       <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            VBL_IRQ     <= 1'b0;
        end else begin
            mode_q      <= mode_nxt;
            nHSYNC      <= !(h_nxt < HSYNC_END);
            CHBL        <= (h_nxt < HBL_END_C) || (h_nxt >= HBL_STRT_C);
            nVSYNC      <= !((v_nxt >= vs_first) && (v_nxt < vs_first + VSYNC_LEN));
            nBNKB       <= !((v_nxt < VBL_END) || (v_nxt >= VBL_START));
            LINE_START  <= h_wrap;
            FRAME_START <= v_wrap;
            VBL_IRQ     <= h_wrap && (v_nxt == VBL_START);
        end
    end

`ifdef LSPC_SNAP_EN
    // Captures the registered V_CNT, i.e. the value before any increment
    // happening on the same edge.
    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            SNAP_V <= 9'd0;
        end else if (SNAP_REQ) begin
            SNAP_V <= V_CNT;
        end
    end
`else
    // No snapshot register: output is constant 0. SNAP_REQ is folded in with
    // a zero mask so the input stays referenced.
    assign SNAP_V = 9'd0 & {9{SNAP_REQ}};
`endif

endmodule

// File: tb/tb_lspc_video_timing.sv
// ---------------------------------------------------------------------------
// tb_lspc_video_timing
// Self-checking bench for lspc_video_timing. A short line length (H_TOTAL=20)
// keeps full NTSC and PAL frames within a small cycle budget; all vertical
// behaviour uses the real raster numbers. A behavioural model tracks the
// raster position per enable and the outputs are derived from it with plain
// range comparisons; a compare process checks every output on every falling
// clock edge, and the directed sequence pins the model with literal values.
// ---------------------------------------------------------------------------
module tb_lspc_video_timing;

    localparam int H_TOTAL   = 20;
    localparam int HSYNC_LEN = 4;
    localparam int HBL_START = 18;
    localparam int HBL_END   = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lspc_en = 1'b0;
    logic       vmode = 1'b0;
    logic       snap_req = 1'b0;
    logic [8:0] h_cnt, v_cnt, snap_v;
    logic       n_hsync, n_vsync, chbl, n_bnkb, line_start, frame_start, vbl_irq;

    always #5 clk = ~clk;

    lspc_video_timing #(
        .H_TOTAL   (H_TOTAL),
        .HSYNC_LEN (HSYNC_LEN),
        .HBL_START (HBL_START),
        .HBL_END   (HBL_END)
    ) dut (
        .CLK          (clk),
        .nRESETP      (rst_n),
        .LSPC_EN_6M_P (lspc_en),
        .VMODE        (vmode),
        .SNAP_REQ     (snap_req),
        .H_CNT        (h_cnt),
        .V_CNT        (v_cnt),
        .nHSYNC       (n_hsync),
        .nVSYNC       (n_vsync),
        .CHBL         (chbl),
        .nBNKB        (n_bnkb),
        .LINE_START   (line_start),
        .FRAME_START  (frame_start),
        .VBL_IRQ      (vbl_irq),
        .SNAP_V       (snap_v)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_h, m_v, m_mode, m_snap;
    bit m_line, m_frame, m_vbl;

    function automatic int first_line(input int mode);
        return (mode != 0) ? 200 : 248;   // 0x0C8 PAL, 0x0F8 NTSC
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 248; m_mode = 0; m_snap = 0;
        m_line = 0; m_frame = 0; m_vbl = 0;
    endtask

    // Called once per rising edge with the inputs that edge saw.
    task automatic model_edge(input bit en, input bit snap);
        if (!rst_n) return;
        m_line = 0; m_frame = 0; m_vbl = 0;
`ifdef LSPC_SNAP_EN
        if (snap) m_snap = m_v;
`endif
        if (en) begin
            if (m_h == H_TOTAL - 1) begin
                m_h = 0;
                m_line = 1;
                if (m_v == 511) begin
                    m_mode = vmode;
                    m_v = first_line(m_mode);
                    m_frame = 1;
                end else begin
                    m_v = m_v + 1;
                end
                if (m_v == 496) m_vbl = 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    // ---------------- compare process + pulse monitors ----------------
    int cnt_line = 0, cnt_frame = 0, cnt_vbl = 0, cnt_both = 0;

    always @(negedge clk) begin
        int f;
        f = first_line(m_mode);
        check("H_CNT", h_cnt, m_h);
        check("V_CNT", v_cnt, m_v);
        check("nHSYNC", n_hsync, !(m_h < HSYNC_LEN));
        check("CHBL", chbl, (m_h < HBL_END) || (m_h >= HBL_START));
        check("nVSYNC", n_vsync, !(m_v >= f && m_v < f + 8));
        check("nBNKB", n_bnkb, !(m_v < 272 || m_v >= 496));
        check("LINE_START", line_start, m_line);
        check("FRAME_START", frame_start, m_frame);
        check("VBL_IRQ", vbl_irq, m_vbl);
        check("SNAP_V", snap_v, m_snap);
        cnt_line  += int'(line_start);
        cnt_frame += int'(frame_start);
        cnt_vbl   += int'(vbl_irq);
        cnt_both  += int'(line_start && frame_start);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit en, input bit snap);
        lspc_en = en;
        snap_req = snap;
        @(posedge clk);
        model_edge(en, snap);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    // Issues exactly n enables with random gaps and random snapshot requests.
    task automatic run_enables(input int n);
        int done = 0;
        while (done < n) begin
            bit e;
            e = ($urandom_range(0, 3) != 0);
            step(e, ($urandom_range(0, 7) == 0));
            if (e) done++;
        end
        idle(1);   // let the final edge's pulses reach the monitors
    endtask

    task automatic run_lines(input int n);
        run_enables(n * H_TOTAL);
    endtask

    task automatic clear_counts();
        cnt_line = 0; cnt_frame = 0; cnt_vbl = 0; cnt_both = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int guard;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst H_CNT", h_cnt, 0);
        check("rst V_CNT", v_cnt, 'h0F8);
        check("rst nHSYNC", n_hsync, 0);
        check("rst nVSYNC", n_vsync, 0);
        check("rst CHBL", chbl, 1);
        check("rst nBNKB", n_bnkb, 0);
        check("rst SNAP_V", snap_v, 0);

        // First line after release.
        rst_n = 1'b1;
        clear_counts();
        run_enables(HSYNC_LEN - 1);
        check("line0 H_CNT", h_cnt, 3);
        check("line0 nHSYNC low", n_hsync, 0);
        run_enables(1);
        check("line0 nHSYNC high", n_hsync, 1);
        run_enables(H_TOTAL - HSYNC_LEN);
        check("line1 H_CNT", h_cnt, 0);
        check("line1 V_CNT", v_cnt, 'h0F9);
        check("line1 pulses", cnt_line, 1);
        check("line1 frames", cnt_frame, 0);

        // Rest of the first NTSC frame.
        run_lines(263);
        check("ntsc wrap V_CNT", v_cnt, 'h0F8);
        check("ntsc wrap H_CNT", h_cnt, 0);
        check("ntsc frame pulses", cnt_frame, 1);
        check("ntsc coincident", cnt_both, 1);
        check("ntsc vbl pulses", cnt_vbl, 1);
        check("ntsc line pulses", cnt_line, 264);

        // Second frame: blanking edges and a mid-frame switch to PAL.
        clear_counts();
        run_lines(24);
        check("vbl end V_CNT", v_cnt, 'h110);
        check("vbl end nBNKB", n_bnkb, 1);
        vmode = 1'b1;
        run_lines(224);
        check("vbl start V_CNT", v_cnt, 'h1F0);
        check("vbl start nBNKB", n_bnkb, 0);
        check("vbl irq pulses", cnt_vbl, 1);
        check("mid-switch no frame", cnt_frame, 0);
        run_lines(16);
        check("pal reload V_CNT", v_cnt, 'h0C8);
        check("ntsc frame length", cnt_line, 264);

        // PAL frame.
        clear_counts();
        run_lines(4);
        check("pal vsync V_CNT", v_cnt, 'h0CC);
        check("pal nVSYNC low", n_vsync, 0);
        run_lines(4);
        check("pal nVSYNC high", n_vsync, 1);
        run_lines(304);
        check("pal wrap V_CNT", v_cnt, 'h0C8);
        check("pal frame length", cnt_line, 312);
        check("pal frame pulses", cnt_frame, 1);

        // Asynchronous reset mid-line with sparse enables.
        vmode = 1'b0;
        guard = 0;
        while (m_h != 13 && guard < 200) begin
            step(1'b1, 1'b0);
            idle(3);
            guard++;
        end
        check("reach H=13", m_h, 13);
        clear_counts();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst H_CNT", h_cnt, 0);
        check("async rst V_CNT", v_cnt, 'h0F8);
        check("async rst LINE_START", line_start, 0);
        idle(3);
        check("rst stray pulses", cnt_line + cnt_frame + cnt_vbl, 0);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        idle(1);
        check("post rst H_CNT", h_cnt, 1);
        check("post rst V_CNT", v_cnt, 'h0F8);

        // Snapshot on the edge that moves V_CNT from 0x120 to 0x121.
        run_enables(H_TOTAL * 41 - 2);
        check("pre snap V_CNT", v_cnt, 'h120);
        check("pre snap H_CNT", h_cnt, H_TOTAL - 1);
        step(1'b1, 1'b1);
        idle(1);
        check("snap V_CNT moved", v_cnt, 'h121);
`ifdef LSPC_SNAP_EN
        check("snap SNAP_V", snap_v, 'h120);
`else
        check("snap SNAP_V", snap_v, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lspc_video_timing.md
# lspc_video_timing

Raster timing generator consuming the 6 MHz pixel-clock enable from the LSPC clock divider. Maintains the horizontal pixel counter and vertical raster counter, and derives sync, blanking and frame/line event strobes for the sprite/fix pipeline, the video DAC path and the 68k interrupt logic. Fully synchronous to the single system clock; all timing advances only on the pixel enable.

## Interface
Parameters:
- H_TOTAL, 384: pixels per line (counter 0..H_TOTAL-1)
- HSYNC_LEN, 28: nHSYNC low for H_CNT 0..HSYNC_LEN-1
- HBL_START, 376 / HBL_END, 56: CHBL high when H_CNT < HBL_END or H_CNT >= HBL_START

Ports:
- CLK  in  1  system clock
- nRESETP  in  1  asynchronous active-low reset
- LSPC_EN_6M_P  in  1  pixel enable, one CLK wide
- VMODE  in  1  0 = NTSC (264 lines), 1 = PAL (312 lines)
- SNAP_REQ  in  1  counter snapshot request (CPU read strobe)
- H_CNT  out  9  pixel counter
- V_CNT  out  9  raster counter
- nHSYNC  out  1  horizontal sync, active low
- nVSYNC  out  1  vertical sync, active low
- CHBL  out  1  horizontal blank
- nBNKB  out  1  vertical blank, active low
- LINE_START  out  1  one-CLK pulse when H_CNT wraps to 0
- FRAME_START  out  1  one-CLK pulse when V_CNT wraps to first line
- VBL_IRQ  out  1  one-CLK pulse at V_CNT = 0x1F0, H_CNT = 0
- SNAP_V  out  9  latched V_CNT

## Operation
- Reset values: H_CNT = 0, V_CNT = 0x0F8, nHSYNC = 0, nVSYNC = 0, CHBL = 1, nBNKB = 0, all pulses 0, SNAP_V = 0, active mode = NTSC.
- H_CNT increments on each LSPC_EN_6M_P; at H_TOTAL-1 wraps to 0 and advances V_CNT.
- V_CNT counts V_FIRST..0x1FF; V_FIRST = 0x0F8 (NTSC) or 0x0C8 (PAL). At 0x1FF with H wrap, reloads V_FIRST.
- VMODE sampled into an active-mode register only when V_CNT reloads; mid-frame changes take effect next frame.
- nVSYNC low for V_CNT in V_FIRST..V_FIRST+7.
- nBNKB low when V_CNT < 0x110 or V_CNT >= 0x1F0 (224 visible lines, both modes).
- All decoded outputs registered from the counters' next values: they change in the same CLK edge as the counters.
- LINE_START/FRAME_START/VBL_IRQ asserted for exactly the CLK cycle following the enable edge causing the event; never asserted without an enable.
- Enable absent: all counters/levels hold; pulses 0.
- Reset mid-line: immediate (asynchronous) return to reset values; first enable after release gives H_CNT = 1.

## Timing
- Latency enable -> counter/decoded output change: 1 CLK.
- Line period: 384 enables; frame: 264x384 (NTSC) or 312x384 (PAL) enables.
- Simultaneous H and V wrap: LINE_START and FRAME_START both pulse in the same cycle.
- SNAP_REQ coincident with a V_CNT change captures the pre-increment V_CNT.

## Configuration
- LSPC_SNAP_EN defined: SNAP_V loads V_CNT on every CLK with SNAP_REQ = 1, holds otherwise.
- Undefined: SNAP_V tied to 0, SNAP_REQ ignored, no snapshot register.

## Structure
- Package lspc_timing_pkg: V_FIRST_NTSC (0x0F8), V_FIRST_PAL (0x0C8), V_LAST (0x1FF), VBL_START (0x1F0), VBL_END (0x110), VSYNC_LEN (8).
- One sub-module lspc_wrap_cnt: 9-bit counter with enable, load value and wrap flag, instantiated for H and V.

## Test plan
- Reset release, 384 enables -> H_CNT 0, V_CNT 0x0F9, one LINE_START pulse; nHSYNC rises after enable 28.
- NTSC frame: 264x384 enables -> V_CNT back to 0x0F8, single FRAME_START coincident with LINE_START.
- Run to V_CNT = 0x1F0 -> VBL_IRQ one CLK, nBNKB falls; at V_CNT = 0x110 nBNKB rises.
- Set VMODE = 1 mid-frame -> current frame still ends at 264 lines; next reload to 0x0C8, frame 312 lines, nVSYNC low 0x0C8..0x0CF.
- Enables spaced 4 CLK apart, reset pulsed at H_CNT = 200 -> immediate H_CNT 0, V_CNT 0x0F8, no stray pulses.
- LSPC_SNAP_EN: SNAP_REQ on the V-increment edge at V_CNT = 0x120 -> SNAP_V = 0x120; without macro SNAP_V stays 0.
